iob_frac_round: RTL and testbench

- Pipelined round-to-nearest-even stage for posit/float fraction fields.
- Takes a DATA_W-bit fraction and a count of LSBs to discard, builds the low-bit mask internally, and derives the guard, sticky and lsb bits.
- Returns the right-justified rounded fraction and a renormalisation carry.
- Sits directly downstream of the mask generator: it instantiates iob_mask to get the discard mask, and its output feeds the packing stage.

---
 rtl/iob_frac_round.sv | 139 +++++++++++++
 tb/tb_iob_frac_round.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_frac_round.sv
// Two-stage round-to-nearest-even for right-shifted fraction fields, with an
// internal iob_mask discard-mask generator. Define IOB_FRAC_ROUND_INEXACT_EN to add inexact_o.

module iob_mask #(
    parameter int DATA_W  = 32,
    parameter int SHIFT_W = $clog2(DATA_W + 1)
) (
    input  logic [SHIFT_W-1:0] sh_i,
    output logic [DATA_W-1:0]  mask_o
);
    // Bit i is set when it lies below the discard count; counts >= DATA_W give all ones.
    always_comb begin
        mask_o = '0;
        for (int i = 0; i < DATA_W; i++) begin
            mask_o[i] = (sh_i > SHIFT_W'(i));
        end
    end
endmodule

module iob_frac_round #(
    parameter int DATA_W  = 32,
    parameter int SHIFT_W = $clog2(DATA_W + 1)
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               cke_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [DATA_W-1:0]  frac_i,
    input  logic [SHIFT_W-1:0] sh_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DATA_W-1:0]  frac_o,
`ifdef IOB_FRAC_ROUND_INEXACT_EN
    output logic               inexact_o,
`endif
    output logic               carry_o
);
    localparam logic [SHIFT_W-1:0] SH_MAX = SHIFT_W'(DATA_W);

    // Handshake: a word moves across an interface on a clock edge where valid,
    // ready and cke_i are all high; valid never drops and data never changes
    // while waiting for ready.
    logic s1_valid;
    logic s2_load;
    logic s1_load;

    assign s2_load    = !out_valid_o || out_ready_i;
    assign s1_load    = !s1_valid || s2_load;
    assign in_ready_o = s1_load;

    logic [SHIFT_W-1:0] sh_sat;
    logic [DATA_W-1:0]  mask;
    logic [DATA_W-1:0]  kept_d;
    logic               guard_d;
    logic               sticky_d;
    logic               lsb_d;
    logic [SHIFT_W-1:0] width_d;

    assign sh_sat = (sh_i > SH_MAX) ? SH_MAX : sh_i;

    iob_mask #(
        .DATA_W (DATA_W),
        .SHIFT_W(SHIFT_W)
    ) u_mask (
        .sh_i  (sh_sat),
        .mask_o(mask)
    );

    // The top set bit of the mask selects the guard position; the rest is sticky.
    assign kept_d   = frac_i >> sh_sat;
    assign guard_d  = |(frac_i & (mask & ~(mask >> 1)));
    assign sticky_d = |(frac_i & (mask >> 1));
    assign lsb_d    = kept_d[0];
    assign width_d  = SH_MAX - sh_sat;

    logic [DATA_W-1:0]  s1_kept;
    logic               s1_guard;
    logic               s1_sticky;
    logic               s1_lsb;
    logic [SHIFT_W-1:0] s1_width;

    logic              round_up;
    logic [DATA_W-1:0] sum;
    logic [DATA_W:0]   kept_pow;
    logic              carry_d;

    // round_up implies a nonzero discard count, so the sum always fits DATA_W bits.
    assign round_up = s1_guard && (s1_sticky || s1_lsb);
    assign sum      = s1_kept + {{(DATA_W-1){1'b0}}, round_up};
    assign kept_pow = {{DATA_W{1'b0}}, 1'b1} << s1_width;
    assign carry_d  = ({1'b0, sum} == kept_pow);

`ifdef IOB_FRAC_ROUND_INEXACT_EN
    logic s1_inexact;
`endif

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            s1_valid    <= 1'b0;
            s1_kept     <= '0;
            s1_guard    <= 1'b0;
            s1_sticky   <= 1'b0;
            s1_lsb      <= 1'b0;
            s1_width    <= '0;
            out_valid_o <= 1'b0;
            frac_o      <= '0;
            carry_o     <= 1'b0;
`ifdef IOB_FRAC_ROUND_INEXACT_EN
            s1_inexact  <= 1'b0;
            inexact_o   <= 1'b0;
`endif
        end else if (cke_i) begin
            if (s1_load) begin
                s1_valid <= in_valid_i;
                if (in_valid_i) begin
                    s1_kept   <= kept_d;
                    s1_guard  <= guard_d;
                    s1_sticky <= sticky_d;
                    s1_lsb    <= lsb_d;
                    s1_width  <= width_d;
`ifdef IOB_FRAC_ROUND_INEXACT_EN
                    s1_inexact <= guard_d | sticky_d;
`endif
                end
            end
            if (s2_load) begin
                out_valid_o <= s1_valid;
                if (s1_valid) begin
                    frac_o  <= sum;
                    carry_o <= carry_d;
`ifdef IOB_FRAC_ROUND_INEXACT_EN
                    inexact_o <= s1_inexact;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_iob_frac_round.sv
// Directed bench for iob_frac_round (DATA_W=8): arithmetic rounding model,
// expected-queue scoreboard, and hand-computed pins.

module tb_iob_frac_round;
    localparam int DATA_W  = 8;
    localparam int SHIFT_W = 4;
`ifdef IOB_FRAC_ROUND_INEXACT_EN
    localparam logic [9:0] CMP_MASK = 10'h3FF;
`else
    localparam logic [9:0] CMP_MASK = 10'h1FF;
`endif

    logic               clk;
    logic               arst_i;
    logic               cke_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [DATA_W-1:0]  frac_i;
    logic [SHIFT_W-1:0] sh_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [DATA_W-1:0]  frac_o;
    logic               carry_o;
    logic               inexact_bit;
`ifdef IOB_FRAC_ROUND_INEXACT_EN
    logic               inexact_o;
    assign inexact_bit = inexact_o;
`else
    assign inexact_bit = 1'b0;
`endif

    iob_frac_round #(
        .DATA_W (DATA_W),
        .SHIFT_W(SHIFT_W)
    ) dut (
        .clk_i      (clk),
        .arst_i     (arst_i),
        .cke_i      (cke_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .frac_i     (frac_i),
        .sh_i       (sh_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .frac_o     (frac_o),
`ifdef IOB_FRAC_ROUND_INEXACT_EN
        .inexact_o  (inexact_o),
`endif
        .carry_o    (carry_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Rounding model from integer arithmetic: {inexact, carry, frac}.
    function automatic logic [9:0] model(input logic [7:0] f, input logic [3:0] s);
        int sh, kept, rem, half, res;
        bit up, c, inx;
        sh   = (s > 4'd8) ? 8 : int'(s);
        kept = int'(f) / (1 << sh);
        rem  = int'(f) % (1 << sh);
        half = (sh == 0) ? 0 : (1 << (sh - 1));
        up   = (sh != 0) && ((rem > half) || (rem == half && (kept % 2) == 1));
        res  = kept + (up ? 1 : 0);
        c    = (res == (1 << (8 - sh)));
        inx  = (rem != 0);
        return {inx, c, res[7:0]};
    endfunction

    // scoreboard / compare process
    logic       hold_pending = 1'b0;
    logic [8:0] hold_val;
    always @(negedge clk) begin
        if (arst_i) begin
            exp_q.delete();
            hold_pending = 1'b0;
            check("reset_out_valid", 32'(out_valid_o), 32'd0);
        end else begin
            if (hold_pending) begin
                check("stall_valid", 32'(out_valid_o), 32'd1);
                check("stall_data", 32'({carry_o, frac_o}), 32'(hold_val));
            end
            if (out_valid_o && out_ready_i && cke_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    check("output_word", 32'({inexact_bit, carry_o, frac_o} & CMP_MASK),
                          32'(e & CMP_MASK));
                end
            end
            if (in_valid_i && in_ready_o && cke_i) exp_q.push_back(model(frac_i, sh_i));
            hold_pending = out_valid_o && !(out_ready_i && cke_i);
            hold_val     = {carry_o, frac_o};
        end
    end

    // driver tasks
    task automatic send(input logic [7:0] f, input logic [3:0] s);
        bit acc;
        acc        = 1'b0;
        in_valid_i = 1'b1;
        frac_i     = f;
        sh_i       = s;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready_o && cke_i && !arst_i;
            @(posedge clk);
            #1;
        end
        in_valid_i = 1'b0;
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic latency_test(input logic [7:0] f, input logic [3:0] s, input logic [7:0] req);
        int lat;
        lat = 0;
        send(f, s);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid_o) begin
                lat = i;
                break;
            end
        end
        check("latency", 32'(lat), 32'd2);
        check("latency_frac", 32'(frac_o), 32'(req));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        arst_i      = 1'b1;
        cke_i       = 1'b1;
        in_valid_i  = 1'b0;
        frac_i      = '0;
        sh_i        = '0;
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_frac", 32'(frac_o), 32'd0);
        check("rst_carry", 32'(carry_o), 32'd0);
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        arst_i = 1'b0;

        // hand-computed pins on the model
        check("pin_b6_3", 32'(model(8'hB6, 4'd3)), 32'h217);
        check("pin_04_3", 32'(model(8'h04, 4'd3)), 32'h200);
        check("pin_0c_3", 32'(model(8'h0C, 4'd3)), 32'h202);
        check("pin_ff_1", 32'(model(8'hFF, 4'd1)), 32'h380);
        check("pin_81_8", 32'(model(8'h81, 4'd8)), 32'h301);
        check("pin_80_8", 32'(model(8'h80, 4'd8)), 32'h200);
        check("pin_81_9", 32'(model(8'h81, 4'd9)), 32'h301);
        check("pin_5a_0", 32'(model(8'h5A, 4'd0)), 32'h05A);

        @(posedge clk);
        #1;
        latency_test(8'hB6, 4'd3, 8'h17);

        // back-to-back directed stream
        send(8'h04, 4'd3);
        send(8'h0C, 4'd3);
        send(8'hFF, 4'd1);
        send(8'h81, 4'd8);
        send(8'h80, 4'd8);
        send(8'h81, 4'd9);
        send(8'hC0, 4'd15);
        send(8'h5A, 4'd0);
        send(8'hFF, 4'd0);
        send(8'h7F, 4'd7);
        send(8'h18, 4'd4);
        send(8'h28, 4'd4);
        repeat (4) @(posedge clk);
        #1;

        // backpressure: A and B taken, C refused until downstream drains
        out_ready_i = 1'b0;
        send(8'hA5, 4'd2);
        send(8'h3B, 4'd5);
        in_valid_i = 1'b1;
        frac_i     = 8'hE7;
        sh_i       = 4'd3;
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        out_ready_i = 1'b1;
        send(8'hE7, 4'd3);
        repeat (4) @(posedge clk);
        #1;

        // clock enable freeze with both stages occupied
        send(8'h3C, 4'd2);
        send(8'h7F, 4'd4);
        begin
            logic [7:0] snap_frac;
            logic       snap_valid;
            cke_i      = 1'b0;
            in_valid_i = 1'b1;
            frac_i     = 8'h96;
            sh_i       = 4'd1;
            snap_frac  = frac_o;
            snap_valid = out_valid_o;
            check("cke_pre_valid", 32'(snap_valid), 32'd1);
            repeat (3) begin
                @(negedge clk);
                check("cke_hold_valid", 32'(out_valid_o), 32'(snap_valid));
                check("cke_hold_frac", 32'(frac_o), 32'(snap_frac));
                @(posedge clk);
                #1;
            end
            cke_i = 1'b1;
            send(8'h96, 4'd1);
        end
        repeat (4) @(posedge clk);
        #1;

        // asynchronous reset with two words in flight
        send(8'h55, 4'd2);
        send(8'hAA, 4'd3);
        #1;
        arst_i = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid_o), 32'd0);
        check("async_rst_frac", 32'(frac_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        arst_i = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(out_valid_o), 32'd0);
        @(posedge clk);
        #1;
        latency_test(8'h0C, 4'd3, 8'h02);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
